stream_decoder: RTL

- Byte-serial successor to the fixed-word instruction decoder.
- Accepts the x86-subset instruction stream one byte per beat from fetch and assembles variable-length instructions: opcode, optional ModRM, optional disp8/imm8/immN.
- Emits one decoded micro-op per instruction to the execute stage over a valid/ready handshake.
- Generalised in datapath width and immediate length. Resolves 0x89 ST/MOV by ModRM.mod, flags illegal encodings, and supports pipeline flush.

---
 rtl/stream_decoder.sv | 350 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/stream_decoder.sv
// stream_decoder: byte-serial x86-subset instruction decoder.
// Assembles opcode / ModRM / immediate bytes into one micro-op and hands it
// to execute over a valid/ready handshake. Illegal encodings become HLT with
// the illegal flag set; flush drops any partial or held instruction.
module stream_decoder #(
  parameter int DATA_W    = 32,
  parameter int IMM_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        op,
  output logic [DATA_W-1:0] im,
  output logic              use_im,
  output logic [1:0]        br,
  output logic [3:0]        cc,
  output logic [2:0]        ra1,
  output logic [2:0]        ra2,
  output logic [2:0]        len,
  output logic              illegal
);

  // FSM states
  localparam logic [1:0] S_OPC   = 2'd0;
  localparam logic [1:0] S_MODRM = 2'd1;
  localparam logic [1:0] S_IMM   = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  // Micro-op encodings
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NEG = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MOV = 4'd11;
  localparam logic [3:0] OP_LD  = 4'd12;
  localparam logic [3:0] OP_ST  = 4'd13;
  localparam logic [3:0] OP_LIL = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  // Branch kinds
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_B    = 2'b10;
  localparam logic [1:0] BR_BCC  = 2'b01;

  // Immediate assembly: the LIL accumulator is resized to DATA_W at the end
  localparam int ACC_W = 8 * IMM_BYTES;
  localparam int FIT_W = (DATA_W > ACC_W) ? DATA_W : ACC_W;
  localparam logic [2:0] LAST_IMM = 3'(IMM_BYTES - 1);

  // Shift amounts are masked to the datapath width only when it is a power of 2
  localparam bit POW2 = ((DATA_W & (DATA_W - 1)) == 0);
  localparam logic [DATA_W-1:0] SH_MASK = DATA_W'(DATA_W - 1);

  logic [1:0]        state, state_n;
  logic [7:0]        opc, opc_n;
  logic [ACC_W-1:0]  acc, acc_n;
  logic [2:0]        cnt, cnt_n;

  logic [3:0]        op_n;
  logic [DATA_W-1:0] im_n;
  logic              use_im_n;
  logic [1:0]        br_n;
  logic [3:0]        cc_n;
  logic [2:0]        ra1_n, ra2_n;
  logic [2:0]        len_n;
  logic              illegal_n;

  logic              consume;
  logic              bad;
  logic [1:0]        mod_f;
  logic [2:0]        reg_f;
  logic [2:0]        rm_f;
  logic [DATA_W-1:0] sx;
  logic [DATA_W-1:0] zx;
  logic [FIT_W-1:0]  fit;

  // Handshake outputs derive directly from the state register and inputs
  assign in_ready  = rst_n && !flush && (state != S_OUT);
  assign out_valid = (state == S_OUT);
  assign consume   = in_valid && in_ready;

  // Next-state and payload decode for the byte currently being consumed
  always_comb begin
    state_n   = state;
    opc_n     = opc;
    acc_n     = acc;
    cnt_n     = cnt;
    op_n      = op;
    im_n      = im;
    use_im_n  = use_im;
    br_n      = br;
    cc_n      = cc;
    ra1_n     = ra1;
    ra2_n     = ra2;
    len_n     = len;
    illegal_n = illegal;
    bad       = 1'b0;

    mod_f = in_byte[7:6];
    reg_f = in_byte[5:3];
    rm_f  = in_byte[2:0];

    sx      = {DATA_W{in_byte[7]}};
    sx[7:0] = in_byte;
    zx      = '0;
    zx[7:0] = in_byte;
    fit     = '0;

    case (state)
      S_OPC: begin
        if (consume) begin
          opc_n     = in_byte;
          acc_n     = '0;
          cnt_n     = 3'd0;
          op_n      = OP_ADD;
          im_n      = '0;
          use_im_n  = 1'b0;
          br_n      = BR_NONE;
          cc_n      = 4'd0;
          ra1_n     = 3'd0;
          ra2_n     = 3'd0;
          len_n     = 3'd1;
          illegal_n = 1'b0;
          casez (in_byte)
            8'hF4: begin
              op_n    = OP_HLT;
              state_n = S_OUT;
            end
            8'h01, 8'h29, 8'h39, 8'h21, 8'h09, 8'h31,
            8'h89, 8'h8B, 8'hF7, 8'h83, 8'hC1: begin
              state_n = S_MODRM;
            end
            8'b1011_1???: begin
              op_n     = OP_LIL;
              ra2_n    = in_byte[2:0];
              use_im_n = 1'b1;
              state_n  = S_IMM;
            end
            8'hEB: begin
              br_n     = BR_B;
              use_im_n = 1'b1;
              state_n  = S_IMM;
            end
            8'b0111_????: begin
              br_n     = BR_BCC;
              cc_n     = in_byte[3:0];
              use_im_n = 1'b1;
              state_n  = S_IMM;
            end
            default: bad = 1'b1;
          endcase
        end
      end

      S_MODRM: begin
        if (consume) begin
          len_n = 3'd2;
          case (opc)
            8'h01, 8'h29, 8'h39, 8'h21, 8'h09, 8'h31: begin
              if (mod_f == 2'b11) begin
                case (opc)
                  8'h01:   op_n = OP_ADD;
                  8'h29:   op_n = OP_SUB;
                  8'h39:   op_n = OP_CMP;
                  8'h21:   op_n = OP_AND;
                  8'h09:   op_n = OP_OR;
                  default: op_n = OP_XOR;
                endcase
                ra1_n   = reg_f;
                ra2_n   = rm_f;
                state_n = S_OUT;
              end else begin
                bad = 1'b1;
              end
            end
            8'h89: begin
              if (mod_f == 2'b11 || mod_f == 2'b00) begin
                op_n    = (mod_f == 2'b11) ? OP_MOV : OP_ST;
                ra1_n   = reg_f;
                ra2_n   = rm_f;
                state_n = S_OUT;
              end else begin
                bad = 1'b1;
              end
            end
            8'h8B: begin
              if (mod_f == 2'b11 || mod_f == 2'b00) begin
                op_n    = (mod_f == 2'b11) ? OP_MOV : OP_LD;
                ra1_n   = rm_f;
                ra2_n   = reg_f;
                state_n = S_OUT;
              end else begin
                bad = 1'b1;
              end
            end
            8'hF7: begin
              if (mod_f == 2'b11 && (reg_f == 3'b010 || reg_f == 3'b011)) begin
                op_n    = (reg_f == 3'b010) ? OP_NOT : OP_NEG;
                ra1_n   = rm_f;
                ra2_n   = rm_f;
                state_n = S_OUT;
              end else begin
                bad = 1'b1;
              end
            end
            8'h83: begin
              if (mod_f == 2'b11) begin
                case (reg_f)
                  3'b000:  op_n = OP_ADD;
                  3'b001:  op_n = OP_OR;
                  3'b100:  op_n = OP_AND;
                  3'b101:  op_n = OP_SUB;
                  3'b110:  op_n = OP_XOR;
                  3'b111:  op_n = OP_CMP;
                  default: bad  = 1'b1;
                endcase
              end else begin
                bad = 1'b1;
              end
              if (!bad) begin
                ra1_n    = rm_f;
                ra2_n    = rm_f;
                use_im_n = 1'b1;
                state_n  = S_IMM;
              end
            end
            default: begin
              if (mod_f == 2'b11) begin
                case (reg_f)
                  3'b100:  op_n = OP_SLL;
                  3'b101:  op_n = OP_SRL;
                  3'b111:  op_n = OP_SRA;
                  default: bad  = 1'b1;
                endcase
              end else begin
                bad = 1'b1;
              end
              if (!bad) begin
                ra1_n    = rm_f;
                ra2_n    = rm_f;
                use_im_n = 1'b1;
                state_n  = S_IMM;
              end
            end
          endcase
        end
      end

      S_IMM: begin
        if (consume) begin
          len_n = len + 3'd1;
          casez (opc)
            8'h83: begin
              im_n    = sx;
              state_n = S_OUT;
            end
            8'hC1: begin
              im_n    = POW2 ? (zx & SH_MASK) : zx;
              state_n = S_OUT;
            end
            8'hEB, 8'b0111_????: begin
              im_n    = sx + DATA_W'(2);
              state_n = S_OUT;
            end
            default: begin
              for (int i = 0; i < IMM_BYTES; i++) begin
                if (cnt == 3'(i)) acc_n[8*i +: 8] = in_byte;
              end
              if (cnt == LAST_IMM) begin
                fit[ACC_W-1:0] = acc_n;
                im_n           = fit[DATA_W-1:0];
                cnt_n          = 3'd0;
                state_n        = S_OUT;
              end else begin
                cnt_n = cnt + 3'd1;
              end
            end
          endcase
        end
      end

      default: begin
        if (out_ready) state_n = S_OPC;
      end
    endcase

    if (bad) begin
      op_n      = OP_HLT;
      illegal_n = 1'b1;
      im_n      = '0;
      use_im_n  = 1'b0;
      br_n      = BR_NONE;
      cc_n      = 4'd0;
      ra1_n     = 3'd0;
      ra2_n     = 3'd0;
      state_n   = S_OUT;
    end

    if (flush) begin
      state_n = S_OPC;
      cnt_n   = 3'd0;
    end
  end

  // Register the decode state and the held micro-op payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_OPC;
      opc     <= 8'h00;
      acc     <= '0;
      cnt     <= 3'd0;
      op      <= 4'd0;
      im      <= '0;
      use_im  <= 1'b0;
      br      <= 2'b00;
      cc      <= 4'd0;
      ra1     <= 3'd0;
      ra2     <= 3'd0;
      len     <= 3'd0;
      illegal <= 1'b0;
    end else begin
      state   <= state_n;
      opc     <= opc_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      op      <= op_n;
      im      <= im_n;
      use_im  <= use_im_n;
      br      <= br_n;
      cc      <= cc_n;
      ra1     <= ra1_n;
      ra2     <= ra2_n;
      len     <= len_n;
      illegal <= illegal_n;
    end
  end

endmodule
